moore_rr_arbiter: RTL and testbench



---
 rtl/moore_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_moore_rr_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/moore_rr_arbiter.sv
// Moore round-robin arbiter: IDLE -> ARB -> GRANT -> RELEASE, registered one-hot grant,
// per-grant hold limit and one dead cycle between consecutive grants.
module moore_rr_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic [1:0]               state,
    output logic                     expired
);

    localparam int unsigned ID_W   = $clog2(N_REQ);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARB     = 2'b01,
        S_GRANT   = 2'b10,
        S_RELEASE = 2'b11
    } state_t;

    state_t              r_state;
    logic [N_REQ-1:0]    r_gnt;
    logic [ID_W-1:0]     r_gnt_id;
    logic [ID_W-1:0]     r_last_id;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_busy;
    logic                r_expired;

    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_idx;
    logic [N_REQ-1:0]    w_one;

    assign w_one = {{(N_REQ-1){1'b0}}, 1'b1};

    // Cyclic priority scan starting just after the last served requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx = ID_W'((32'(r_last_id) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_last_id  <= ID_W'(N_REQ - 1);
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
            r_expired  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_gnt     <= '0;
                    r_busy    <= 1'b0;
                    r_expired <= 1'b0;
                    if (|req) begin
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (w_found) begin
                        r_gnt_id   <= w_winner;
                        r_gnt      <= w_one << w_winner;
                        r_hold_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_GRANT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    // A drop wins over a coincident timeout, so expired stays low then.
                    if (!req[r_gnt_id]) begin
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_last_id <= r_gnt_id;
                        r_state   <= S_RELEASE;
                    end else if (r_hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_expired <= 1'b1;
                        r_last_id <= r_gnt_id;
                        r_state   <= S_RELEASE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                S_RELEASE: begin
                    r_expired <= 1'b0;
                    r_state   <= (|req) ? S_ARB : S_IDLE;
                end
                default: begin
                    r_gnt     <= '0;
                    r_busy    <= 1'b0;
                    r_expired <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign state   = r_state;
    assign expired = r_expired;

endmodule

// File: tb/tb_moore_rr_arbiter.sv
// Directed bench for moore_rr_arbiter (N_REQ=4, MAX_HOLD=8) with hand-computed expectations.
module tb_moore_rr_arbiter;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [1:0] state;
    logic       expired;

    int n_checks = 0;
    int n_pass   = 0;

    moore_rr_arbiter #(.N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .state   (state),
        .expired (expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle; inputs are changed only at these points.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the edge into GRANT; request stays high so the grant times out.
    task automatic full_grant(input int id);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        for (int c = 0; c < 8; c++) begin
            check("hold_gnt", gnt, oh);
            check("hold_id", gnt_id, id);
            check("hold_busy", busy, 1);
            check("hold_state", state, 2);
            if (c < 7) tick();
        end
        tick();
        check("to_rel_state", state, 3);
        check("to_rel_gnt", gnt, 0);
        check("to_rel_busy", busy, 0);
        check("to_rel_expired", expired, 1);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        tick();
        check("rst_state", state, 0);
        check("rst_gnt", gnt, 0);
        check("rst_id", gnt_id, 0);
        check("rst_busy", busy, 0);
        check("rst_expired", expired, 0);
        reset = 1'b0;

        // Single requester, released after 3 grant cycles.
        req = 4'b0001;
        tick();
        check("t1_arb_state", state, 1);
        check("t1_arb_gnt", gnt, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t1_gnt", gnt, 4'b0001);
            check("t1_busy", busy, 1);
            check("t1_state", state, 2);
        end
        req = 4'b0000;
        tick();
        check("t1_rel_state", state, 3);
        check("t1_rel_gnt", gnt, 0);
        check("t1_rel_busy", busy, 0);
        check("t1_rel_expired", expired, 0);
        tick();
        check("t1_idle_state", state, 0);

        // All requesting: timeouts rotate 0,1,2,3,0,1,2.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t2_rst_state", state, 0);
        req = 4'b1111;
        tick();
        check("t2_arb0", state, 1);
        for (int g = 0; g < 7; g++) begin
            tick();
            full_grant(g % 4);
            if (g < 6) begin
                tick();
                check("t2_arb_state", state, 1);
                check("t2_arb_expired", expired, 0);
                check("t2_arb_gnt", gnt, 0);
            end
        end

        // After id 2, 0101 wraps to 0; then 0101 again picks 2.
        req = 4'b0101;
        tick();
        check("t3_arb_state", state, 1);
        tick();
        check("t3_wrap_id", gnt_id, 0);
        check("t3_wrap_gnt", gnt, 4'b0001);
        req = 4'b0100;
        tick();
        check("t3_rel_state", state, 3);
        check("t3_rel_expired", expired, 0);
        req = 4'b0101;
        tick();
        check("t3_arb2_state", state, 1);
        tick();
        check("t3_next_id", gnt_id, 2);
        check("t3_next_gnt", gnt, 4'b0100);

        // Drop coincides with the last allowed hold cycle.
        for (int c = 0; c < 7; c++) tick();
        check("t4_last_gnt", gnt, 4'b0100);
        check("t4_last_state", state, 2);
        req = 4'b0001;
        tick();
        check("t4_rel_state", state, 3);
        check("t4_rel_expired", expired, 0);
        check("t4_rel_gnt", gnt, 0);
        tick();
        check("t4_arb_state", state, 1);
        tick();
        check("t4_next_id", gnt_id, 0);
        req = 4'b0000;
        tick();
        tick();
        check("t4_idle_state", state, 0);

        // Reset during GRANT of id 1 restores requester-0 priority.
        req = 4'b1111;
        tick();
        tick();
        check("t5_gnt_id", gnt_id, 1);
        check("t5_gnt", gnt, 4'b0010);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_state", state, 0);
        check("t5_rst_gnt", gnt, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_id", gnt_id, 0);
        tick();
        check("t5_arb_state", state, 1);
        tick();
        check("t5_after_id", gnt_id, 0);
        check("t5_after_gnt", gnt, 4'b0001);
        req = 4'b0000;
        tick();
        tick();
        check("t5_idle_state", state, 0);

        // One-cycle request pulse: ARB sees nothing and falls back to IDLE.
        req = 4'b0100;
        tick();
        check("t6_arb_state", state, 1);
        req = 4'b0000;
        tick();
        check("t6_idle_state", state, 0);
        check("t6_gnt", gnt, 0);
        tick();
        check("t6_idle2_state", state, 0);
        check("t6_gnt2", gnt, 0);
        check("t6_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
